sample_packer: RTL and testbench
================================

// Module: sample_packer
// PURPOSE
//  Downstream stage of the 2-bit acquisition input register. Packs successive
//  2-bit samples into 8-bit words, buffers them in a small FIFO and presents
//  them to the storage/transmit side on a valid/ready handshake.
//  Flags lost words (sticky overflow) and supports flushing a partial word.
// PARAMETERS
//  SAMPLE_W    2  width of one sample (fixed at 2; word = 4 samples)
//  FIFO_DEPTH  4  word FIFO entries; must be a power of 2
//  ADDR_W      2  log2(FIFO_DEPTH)
// PORTS
//  new_clk      in   1         single system clock, all logic on posedge
//  reset        in   1         synchronous, active-high reset
//  sample_valid in   1         sample_in is a new sample this cycle
//  sample_in    in   SAMPLE_W  sample from the input register's reg_out
//  flush        in   1         zero-pad and push the current partial word
//  clear_ovf    in   1         clear the sticky overflow flag
//  word_ready   in   1         consumer accepts word_data this cycle
//  word_data    out  8         FIFO head word (first-word fall-through)
//  word_valid   out  1         word_data is valid (FIFO not empty)
//  fifo_count   out  ADDR_W+1  words currently held, 0..FIFO_DEPTH
//  partial      out  1         packer holds 1..3 unpushed samples
//  overflow     out  1         sticky: a completed word was dropped
// BEHAVIOUR
//  Reset (sync, reset=1 at posedge): slot counter=0, shift reg=0, FIFO
//   memory=0, pointers=0; outputs word_data=0, word_valid=0, fifo_count=0,
//   partial=0, overflow=0. Reset overrides every other input in that cycle.
//  Packing: slot counter 0..3 selects sample position; first sample ->
//   bits[1:0], second -> [3:2], third -> [5:4], fourth -> [7:6].
//  sample_valid at slot 0..2: store sample, slot+1. At slot 3: word
//   {sample_in, shift[5:0]} is pushed the same edge, slot wraps to 0.
//  flush=1: if slot!=0 or sample_valid=1, the sample (if any) is stored in
//   the current slot, remaining upper slots are zero, word pushed, slot=0.
//   flush with slot=0 and no sample_valid is a no-op (no empty word pushed).
//  partial = (slot != 0), registered.
//  FIFO: pop when word_valid && word_ready. Push accepted when
//   fifo_count<FIFO_DEPTH, or when full and a pop occurs the same cycle.
//   Simultaneous push+pop: count unchanged. Pointers wrap modulo FIFO_DEPTH.
//  Drop: push while full with no pop -> word discarded, FIFO unchanged,
//   overflow<=1; slot still returns to 0.
//  overflow: cleared by clear_ovf; a drop in the same cycle wins (stays 1).
//  Latency: word completed at edge N -> word_valid=1 after edge N when FIFO
//   was empty; word_data = FIFO head combinationally from memory/read ptr.
//  word_data/word_valid hold stable while word_valid=1 and word_ready=0.
//  No combinational path from sample_valid/sample_in to any output.
// TESTING
//  1 reset, then samples 1,2,3,0 on 4 consecutive cycles, ready=1 -> one
//    word 8'h39, word_valid 1 cycle after 4th sample, fifo_count 1->0.
//  2 ready=0, push 5 words (20 samples of 2'b11) -> fifo_count=4, 5th word
//    dropped, overflow=1; clear_ovf -> overflow=0; drain gives 4x 8'hFF.
//  3 full FIFO, ready=1 on same cycle 5th word completes -> no drop,
//    overflow stays 0, fifo_count stays 4.
//  4 samples 2,1 then flush (no sample) -> word 8'h06 pushed, partial 1->0;
//    flush with slot=0 -> fifo_count unchanged.
//  5 3 samples in, reset asserted mid-word -> all outputs 0, next 4 samples
//    form a fresh word with first sample in bits[1:0].
//  6 ready toggling 1/0 every cycle during continuous sampling -> words
//    delivered in order, no loss, no duplicates, pointer wrap verified.

Source files
------------

// File: rtl/sample_packer.sv
// Packs 2-bit samples into 8-bit words (first sample in the LSBs) and queues
// them in a small first-word-fall-through FIFO with a sticky drop flag.
module sample_packer #(
    parameter int SAMPLE_W   = 2,
    parameter int FIFO_DEPTH = 4,
    parameter int ADDR_W     = 2
) (
    input  logic                    new_clk,
    input  logic                    reset,
    input  logic                    sample_valid,
    input  logic [SAMPLE_W-1:0]     sample_in,
    input  logic                    flush,
    input  logic                    clear_ovf,
    input  logic                    word_ready,
    output logic [4*SAMPLE_W-1:0]   word_data,
    output logic                    word_valid,
    output logic [ADDR_W:0]         fifo_count,
    output logic                    partial,
    output logic                    overflow
);

    localparam int              WORD_W   = 4 * SAMPLE_W;
    localparam logic [ADDR_W:0] FULL_CNT = (ADDR_W + 1)'(FIFO_DEPTH);

    logic [1:0]            r_slot;
    logic [3*SAMPLE_W-1:0] r_shift;
    logic [WORD_W-1:0]     r_mem [FIFO_DEPTH];
    logic [ADDR_W-1:0]     r_wptr;
    logic [ADDR_W-1:0]     r_rptr;
    logic [ADDR_W:0]       r_count;
    logic                  r_ovf;

    logic [WORD_W-1:0]     w_samp_sh;
    logic [WORD_W-1:0]     w_word;
    logic                  w_done;
    logic                  w_pop;
    logic                  w_push;
    logic                  w_drop;

    // Incoming sample moved to its slot position; zero when no sample arrives.
    always_comb begin
        w_samp_sh = '0;
        if (sample_valid) begin
            case (r_slot)
                2'd0:    w_samp_sh = {{3*SAMPLE_W{1'b0}}, sample_in};
                2'd1:    w_samp_sh = {{2*SAMPLE_W{1'b0}}, sample_in, {SAMPLE_W{1'b0}}};
                2'd2:    w_samp_sh = {{SAMPLE_W{1'b0}}, sample_in, {2*SAMPLE_W{1'b0}}};
                default: w_samp_sh = {sample_in, {3*SAMPLE_W{1'b0}}};
            endcase
        end
    end

    // The shift register is cleared whenever a word leaves, so unused upper
    // slots are already zero and a flushed word comes out zero-padded.
    assign w_word = {{SAMPLE_W{1'b0}}, r_shift} | w_samp_sh;
    assign w_done = (sample_valid && (r_slot == 2'd3))
                  || (flush && ((r_slot != 2'd0) || sample_valid));
    assign w_pop  = word_valid && word_ready;
    assign w_push = w_done && ((r_count != FULL_CNT) || w_pop);
    assign w_drop = w_done && !w_push;

    always_ff @(posedge new_clk) begin
        if (reset) begin
            r_slot  <= 2'd0;
            r_shift <= '0;
        end else if (w_done) begin
            r_slot  <= 2'd0;
            r_shift <= '0;
        end else if (sample_valid) begin
            r_slot  <= r_slot + 2'd1;
            r_shift <= r_shift | w_samp_sh[3*SAMPLE_W-1:0];
        end
    end

    always_ff @(posedge new_clk) begin
        if (reset) begin
            r_wptr  <= '0;
            r_rptr  <= '0;
            r_count <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                r_mem[i] <= '0;
            end
        end else begin
            if (w_push) begin
                r_mem[r_wptr] <= w_word;
                r_wptr        <= r_wptr + 1'b1;
            end
            if (w_pop) begin
                r_rptr <= r_rptr + 1'b1;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 1'b1;
                2'b01:   r_count <= r_count - 1'b1;
                default: r_count <= r_count;
            endcase
        end
    end

    // A drop in the same cycle as clear_ovf keeps the flag set.
    always_ff @(posedge new_clk) begin
        if (reset) begin
            r_ovf <= 1'b0;
        end else if (w_drop) begin
            r_ovf <= 1'b1;
        end else if (clear_ovf) begin
            r_ovf <= 1'b0;
        end
    end

    assign word_data  = r_mem[r_rptr];
    assign word_valid = (r_count != '0);
    assign fifo_count = r_count;
    assign partial    = (r_slot != 2'd0);
    assign overflow   = r_ovf;

endmodule

// File: tb/tb_sample_packer.sv
// Bench for sample_packer: fixed vector table, directed multi-cycle corner
// cases, and random traffic checked against a queue-based reference model.
module tb_sample_packer;

    logic       new_clk = 1'b0;
    logic       reset = 1'b0;
    logic       sample_valid = 1'b0;
    logic [1:0] sample_in = 2'd0;
    logic       flush = 1'b0;
    logic       clear_ovf = 1'b0;
    logic       word_ready = 1'b0;
    logic [7:0] word_data;
    logic       word_valid;
    logic [2:0] fifo_count;
    logic       partial;
    logic       overflow;

    int checks = 0;
    int errors = 0;

    sample_packer #(.SAMPLE_W(2), .FIFO_DEPTH(4), .ADDR_W(2)) dut (
        .new_clk      (new_clk),
        .reset        (reset),
        .sample_valid (sample_valid),
        .sample_in    (sample_in),
        .flush        (flush),
        .clear_ovf    (clear_ovf),
        .word_ready   (word_ready),
        .word_data    (word_data),
        .word_valid   (word_valid),
        .fifo_count   (fifo_count),
        .partial      (partial),
        .overflow     (overflow)
    );

    always #5 new_clk = ~new_clk;

    typedef struct {
        logic       rst;
        logic       sv;
        logic [1:0] s;
        logic       fl;
        logic       clr;
        logic       rdy;
        logic       ev;
        logic [7:0] ed;
        logic       dchk;
        logic [2:0] ec;
        logic       ep;
        logic       eo;
    } vec_t;

    vec_t tbl [13];

    // Reference model state: pending samples and queued words.
    int         m_pend [$];
    logic [7:0] m_fifo [$];
    logic       m_ovf;

    task automatic chk(input string name, input int act, input int req);
        checks++;
        if (act != req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic tick();
        @(posedge new_clk);
        #1;
    endtask

    task automatic drive(input logic rst, input logic sv, input logic [1:0] s,
                         input logic fl, input logic clr, input logic rdy);
        reset        = rst;
        sample_valid = sv;
        sample_in    = s;
        flush        = fl;
        clear_ovf    = clr;
        word_ready   = rdy;
    endtask

    task automatic do_reset();
        drive(1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
    endtask

    // Advance the model by one clock using the inputs applied this cycle.
    task automatic model_step(input logic rst, input logic sv, input logic [1:0] s,
                              input logic fl, input logic clr, input logic rdy);
        int  w;
        bit  done;
        bit  pop;
        int  size_before;
        if (rst) begin
            m_pend.delete();
            m_fifo.delete();
            m_ovf = 1'b0;
            return;
        end
        size_before = m_fifo.size();
        pop = (size_before > 0) && rdy;
        if (sv) m_pend.push_back(int'(s));
        done = (m_pend.size() == 4) || (fl && m_pend.size() > 0);
        w = 0;
        if (done) begin
            for (int i = 0; i < m_pend.size(); i++) w += m_pend[i] * (4 ** i);
            m_pend.delete();
        end
        if (pop) void'(m_fifo.pop_front());
        if (clr) m_ovf = 1'b0;
        if (done) begin
            if (size_before < 4 || pop) m_fifo.push_back(8'(w));
            else m_ovf = 1'b1;
        end
    endtask

    logic [7:0] exp_q [$];
    logic [7:0] got_q [$];

    initial begin
        // rst sv s fl clr rdy | valid data dchk count partial ovf
        tbl[0]  = '{1'b1, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0, 1'b0, 8'h00, 1'b1, 3'd0, 1'b0, 1'b0};
        tbl[1]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b1, 3'd0, 1'b1, 1'b0};
        tbl[2]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[3]  = '{1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[4]  = '{1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b1, 1'b1, 8'h39, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[5]  = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[6]  = '{1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[7]  = '{1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b1, 1'b0};
        tbl[8]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b1, 1'b1, 8'h06, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[9]  = '{1'b0, 1'b0, 2'd0, 1'b1, 1'b0, 1'b0, 1'b1, 8'h06, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[10] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};
        tbl[11] = '{1'b0, 1'b1, 2'd3, 1'b1, 1'b0, 1'b0, 1'b1, 8'h03, 1'b1, 3'd1, 1'b0, 1'b0};
        tbl[12] = '{1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1, 1'b0, 8'h00, 1'b0, 3'd0, 1'b0, 1'b0};

        #1;
        for (int i = 0; i < 13; i++) begin
            drive(tbl[i].rst, tbl[i].sv, tbl[i].s, tbl[i].fl, tbl[i].clr, tbl[i].rdy);
            tick();
            chk($sformatf("tbl%0d_valid", i), int'(word_valid), int'(tbl[i].ev));
            chk($sformatf("tbl%0d_count", i), int'(fifo_count), int'(tbl[i].ec));
            chk($sformatf("tbl%0d_partial", i), int'(partial), int'(tbl[i].ep));
            chk($sformatf("tbl%0d_ovf", i), int'(overflow), int'(tbl[i].eo));
            if (tbl[i].dchk) chk($sformatf("tbl%0d_data", i), int'(word_data), int'(tbl[i].ed));
        end

        // Fill with ready low: 5th word is dropped, flag is sticky until cleared.
        do_reset();
        for (int i = 0; i < 20; i++) begin
            drive(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0);
            tick();
            if (i == 15) begin
                chk("ovf_full_count", int'(fifo_count), 4);
                chk("ovf_not_yet", int'(overflow), 0);
            end
        end
        chk("ovf_count_after_drop", int'(fifo_count), 4);
        chk("ovf_set", int'(overflow), 1);
        chk("ovf_partial", int'(partial), 0);
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b1, 1'b0);
        tick();
        chk("ovf_cleared", int'(overflow), 0);
        for (int i = 0; i < 4; i++) begin
            drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
            chk($sformatf("drain%0d_valid", i), int'(word_valid), 1);
            chk($sformatf("drain%0d_data", i), int'(word_data), 8'hFF);
            tick();
        end
        chk("drain_empty", int'(fifo_count), 0);
        chk("drain_valid_low", int'(word_valid), 0);

        // Full FIFO, pop on the same edge the next word completes: no drop.
        do_reset();
        for (int i = 0; i < 19; i++) begin
            drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("full_pre_count", int'(fifo_count), 4);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b1);
        tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("pushpop_count", int'(fifo_count), 4);
        chk("pushpop_ovf", int'(overflow), 0);
        chk("pushpop_data", int'(word_data), 8'hAA);

        // Reset mid-word discards the partial samples.
        do_reset();
        for (int i = 1; i <= 3; i++) begin
            drive(1'b0, 1'b1, 2'(i), 1'b0, 1'b0, 1'b0);
            tick();
        end
        chk("mid_partial", int'(partial), 1);
        drive(1'b1, 1'b1, 2'd3, 1'b1, 1'b0, 1'b1);
        tick();
        chk("midrst_partial", int'(partial), 0);
        chk("midrst_valid", int'(word_valid), 0);
        chk("midrst_count", int'(fifo_count), 0);
        chk("midrst_data", int'(word_data), 0);
        chk("midrst_ovf", int'(overflow), 0);
        drive(1'b0, 1'b1, 2'd2, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 2'd0, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 2'd1, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b1, 2'd3, 1'b0, 1'b0, 1'b0); tick();
        drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("fresh_count", int'(fifo_count), 1);
        chk("fresh_data", int'(word_data), 8'hD2);

        // Continuous sampling with ready toggling: in-order, lossless, wraps.
        do_reset();
        exp_q.delete();
        got_q.delete();
        begin
            int acc = 0;
            for (int i = 0; i < 120; i++) begin
                logic [1:0] s;
                s = 2'($urandom_range(3));
                acc += int'(s) * (4 ** (i % 4));
                if (i % 4 == 3) begin
                    exp_q.push_back(8'(acc));
                    acc = 0;
                end
                drive(1'b0, 1'b1, s, 1'b0, 1'b0, 1'(i % 2));
                if (word_valid && word_ready) got_q.push_back(word_data);
                tick();
            end
            for (int i = 0; i < 12; i++) begin
                drive(1'b0, 1'b0, 2'd0, 1'b0, 1'b0, 1'b1);
                if (word_valid && word_ready) got_q.push_back(word_data);
                tick();
            end
        end
        chk("stream_words", got_q.size(), exp_q.size());
        chk("stream_ovf", int'(overflow), 0);
        for (int i = 0; i < exp_q.size(); i++) begin
            if (i < got_q.size()) chk($sformatf("stream%0d", i), int'(got_q[i]), int'(exp_q[i]));
        end

        // Random traffic against the reference model.
        do_reset();
        m_pend.delete();
        m_fifo.delete();
        m_ovf = 1'b0;
        for (int i = 0; i < 1500; i++) begin
            logic rst, sv, fl, clr, rdy;
            logic [1:0] s;
            rst = ($urandom_range(99) < 2);
            sv  = ($urandom_range(99) < 70);
            s   = 2'($urandom_range(3));
            fl  = ($urandom_range(99) < 8);
            clr = ($urandom_range(99) < 10);
            rdy = ($urandom_range(99) < 45);
            drive(rst, sv, s, fl, clr, rdy);
            model_step(rst, sv, s, fl, clr, rdy);
            tick();
            chk("rnd_valid", int'(word_valid), int'(m_fifo.size() > 0));
            chk("rnd_count", int'(fifo_count), m_fifo.size());
            chk("rnd_partial", int'(partial), int'(m_pend.size() > 0));
            chk("rnd_ovf", int'(overflow), int'(m_ovf));
            if (m_fifo.size() > 0) chk("rnd_data", int'(word_data), int'(m_fifo[0]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
